// File: rtl/qoa_slice_sequencer_pkg.sv
// Shared types and constants for the QOA slice sequencer: dequantisation table,
// per-channel LMS state record and the sequencer state encoding.
package qoa_pkg;

    localparam int SLICE_LEN = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        SAVE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [3:0][15:0] history;
        logic [3:0][15:0] weights;
    } lms_state_t;

    // Row = scalefactor, column = 3-bit residual code.
    localparam logic signed [16:0] dequant_tab [16][8] = '{
        '{17'sd1,    -17'sd1,    17'sd3,    -17'sd3,    17'sd5,    -17'sd5,    17'sd7,     -17'sd7},
        '{17'sd5,    -17'sd5,    17'sd18,   -17'sd18,   17'sd32,   -17'sd32,   17'sd49,    -17'sd49},
        '{17'sd16,   -17'sd16,   17'sd53,   -17'sd53,   17'sd95,   -17'sd95,   17'sd147,   -17'sd147},
        '{17'sd34,   -17'sd34,   17'sd113,  -17'sd113,  17'sd203,  -17'sd203,  17'sd315,   -17'sd315},
        '{17'sd63,   -17'sd63,   17'sd210,  -17'sd210,  17'sd378,  -17'sd378,  17'sd588,   -17'sd588},
        '{17'sd104,  -17'sd104,  17'sd345,  -17'sd345,  17'sd621,  -17'sd621,  17'sd966,   -17'sd966},
        '{17'sd158,  -17'sd158,  17'sd528,  -17'sd528,  17'sd950,  -17'sd950,  17'sd1477,  -17'sd1477},
        '{17'sd228,  -17'sd228,  17'sd760,  -17'sd760,  17'sd1368, -17'sd1368, 17'sd2128,  -17'sd2128},
        '{17'sd316,  -17'sd316,  17'sd1053, -17'sd1053, 17'sd1895, -17'sd1895, 17'sd2947,  -17'sd2947},
        '{17'sd422,  -17'sd422,  17'sd1405, -17'sd1405, 17'sd2529, -17'sd2529, 17'sd3934,  -17'sd3934},
        '{17'sd548,  -17'sd548,  17'sd1828, -17'sd1828, 17'sd3290, -17'sd3290, 17'sd5117,  -17'sd5117},
        '{17'sd696,  -17'sd696,  17'sd2320, -17'sd2320, 17'sd4176, -17'sd4176, 17'sd6496,  -17'sd6496},
        '{17'sd868,  -17'sd868,  17'sd2893, -17'sd2893, 17'sd5207, -17'sd5207, 17'sd8099,  -17'sd8099},
        '{17'sd1064, -17'sd1064, 17'sd3548, -17'sd3548, 17'sd6386, -17'sd6386, 17'sd9933,  -17'sd9933},
        '{17'sd1286, -17'sd1286, 17'sd4288, -17'sd4288, 17'sd7718, -17'sd7718, 17'sd12005, -17'sd12005},
        '{17'sd1536, -17'sd1536, 17'sd5120, -17'sd5120, 17'sd9216, -17'sd9216, 17'sd14336, -17'sd14336}
    };

    function automatic logic signed [16:0] dequant(input logic [3:0] sf, input logic [2:0] q);
        return dequant_tab[sf][q];
    endfunction

endpackage

// File: rtl/qoa_slice_sequencer_if.sv
// Slice input and sample output streams of the QOA slice sequencer.
interface qoa_slice_sequencer_if;

    logic               slice_valid;
    logic               slice_ready;
    logic [63:0]        slice_data;
    logic [2:0]         slice_ch;

    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_sample;
    logic [2:0]         out_ch;
    logic               out_last;

    modport master (
        output slice_valid, slice_data, slice_ch, out_ready,
        input  slice_ready, out_valid, out_sample, out_ch, out_last
    );

    modport slave (
        input  slice_valid, slice_data, slice_ch, out_ready,
        output slice_ready, out_valid, out_sample, out_ch, out_last
    );

endinterface

// File: rtl/qoa_slice_sequencer_dequant.sv
// Combinational residual dequantiser: scalefactor and 3-bit code to signed residual.
module qoa_dequant
    import qoa_pkg::*;
(
    input  logic [3:0]         sf,
    input  logic [2:0]         q,
    output logic signed [16:0] r
);

    // table lookup
    always_comb begin
        r = dequant(sf, q);
    end

endmodule

// File: rtl/qoa_slice_sequencer.sv
// Sequences 20-residual QOA slices through a shared LMS predictor, keeping
// per-channel LMS state in a local table.
module qoa_slice_sequencer
    import qoa_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    qoa_slice_sequencer_if.slave     sif,
    input  logic                     st_wr,
    input  logic [2:0]               st_ch,
    input  logic [3:0][15:0]         st_history,
    input  logic [3:0][15:0]         st_weights,
    output logic                     lms_load,
    output logic [3:0][15:0]         lms_load_history,
    output logic [3:0][15:0]         lms_load_weights,
    input  logic signed [31:0]       lms_prediction,
    output logic                     lms_update,
    output logic signed [31:0]       lms_sample,
    output logic signed [27:0]       lms_delta,
    input  logic [3:0][15:0]         lms_save_history,
    input  logic [3:0][15:0]         lms_save_weights,
    output logic                     err
);

    seq_state_t         state_r;
    seq_state_t         state_s;
    lms_state_t         tab_r [NUM_CH];
    lms_state_t         load_s;
    logic [63:0]        slice_r;
    logic [2:0]         ch_r;
    logic [4:0]         k_r;
    logic               err_r;
    logic               accept_s;
    logic               bad_ch_s;
    logic               fire_s;
    logic               k_last_s;
    logic signed [16:0] r_s;
    logic signed [32:0] sum_s;
    logic signed [15:0] clamp_s;
    logic signed [27:0] delta_s;

    assign accept_s = sif.slice_valid & sif.slice_ready;
    assign bad_ch_s = ({1'b0, sif.slice_ch} >= 4'(NUM_CH));
    assign fire_s   = (state_r == RUN) & sif.out_ready;
    assign k_last_s = (k_r == 5'(SLICE_LEN - 1));
    assign err      = err_r;

    // The current residual code always sits at bits 59:57 of the shifted slice.
    qoa_dequant u_dequant (
        .sf (slice_r[63:60]),
        .q  (slice_r[59:57]),
        .r  (r_s)
    );

    // prediction plus residual, saturated to 16 bits
    always_comb begin
        sum_s   = 33'(lms_prediction) + 33'(r_s);
        delta_s = 28'(r_s) >>> 4;
        if (sum_s > 33'sd32767) begin
            clamp_s = 16'sd32767;
        end else if (sum_s < -33'sd32768) begin
            clamp_s = -16'sd32768;
        end else begin
            clamp_s = sum_s[15:0];
        end
    end

    // select the table entry of the latched channel
    always_comb begin
        load_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load_s = (ch_r == 3'(i)) ? tab_r[i] : load_s;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next-state and stream/LMS output decode
    always_comb begin
        state_s          = state_r;
        sif.slice_ready  = 1'b0;
        sif.out_valid    = 1'b0;
        sif.out_sample   = 16'sd0;
        sif.out_last     = 1'b0;
        sif.out_ch       = ch_r;
        lms_load         = 1'b0;
        lms_load_history = '0;
        lms_load_weights = '0;
        lms_update       = 1'b0;
        lms_delta        = 28'sd0;
        case (state_r)
            IDLE: begin
                sif.slice_ready = ~rst;
                if (accept_s && !bad_ch_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                lms_load         = 1'b1;
                lms_load_history = load_s.history;
                lms_load_weights = load_s.weights;
                state_s          = RUN;
            end
            RUN: begin
                sif.out_valid  = 1'b1;
                sif.out_sample = clamp_s;
                sif.out_last   = k_last_s;
                lms_update     = sif.out_ready;
                lms_delta      = delta_s;
                if (fire_s && k_last_s) begin
                    state_s = SAVE;
                end else begin
                    state_s = RUN;
                end
            end
            SAVE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign lms_sample = 32'(sif.out_sample);

    // slice latch, residual shift and sample index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_r <= 64'd0;
            ch_r    <= 3'd0;
            k_r     <= 5'd0;
            err_r   <= 1'b0;
        end else begin
            err_r <= accept_s & bad_ch_s;
            if (accept_s && !bad_ch_s) begin
                slice_r <= sif.slice_data;
                ch_r    <= sif.slice_ch;
                k_r     <= 5'd0;
            end else if (fire_s) begin
                slice_r <= {slice_r[63:60], slice_r[56:0], 3'b000};
                k_r     <= k_last_s ? 5'd0 : (k_r + 5'd1);
            end
        end
    end

    // Header state writes take priority over the end-of-slice save.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tab_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (st_wr && (st_ch == 3'(i))) begin
                    tab_r[i] <= '{history: st_history, weights: st_weights};
                end else if ((state_r == SAVE) && (ch_r == 3'(i))) begin
                    tab_r[i] <= '{history: lms_save_history, weights: lms_save_weights};
                end
            end
        end
    end

endmodule

// File: tb/tb_qoa_slice_sequencer.sv
// Bench for qoa_slice_sequencer: behavioural LMS attached to the LMS ports,
// golden QOA decoder feeding an expected-sample queue, vector table plus corner sequences.
module tb_qoa_slice_sequencer;

    localparam int NUM_CH = 2;
    localparam int SFT [16] = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928, 1157, 1419, 1715, 2048};

    logic clk = 1'b0;
    logic rst = 1'b1;
    qoa_slice_sequencer_if sif();
    logic               st_wr = 1'b0;
    logic [2:0]         st_ch = 3'd0;
    logic [3:0][15:0]   st_history = '0, st_weights = '0;
    logic               lms_load, lms_update, err;
    logic [3:0][15:0]   lms_load_history, lms_load_weights, lms_save_history, lms_save_weights;
    logic signed [31:0] lms_prediction, lms_sample;
    logic signed [27:0] lms_delta;

    qoa_slice_sequencer #(.NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst), .sif(sif),
        .st_wr(st_wr), .st_ch(st_ch), .st_history(st_history), .st_weights(st_weights),
        .lms_load(lms_load), .lms_load_history(lms_load_history), .lms_load_weights(lms_load_weights),
        .lms_prediction(lms_prediction), .lms_update(lms_update), .lms_sample(lms_sample),
        .lms_delta(lms_delta), .lms_save_history(lms_save_history), .lms_save_weights(lms_save_weights),
        .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural LMS predictor driven by the DUT.
    logic signed [15:0] eh [4];
    logic signed [15:0] ew [4];
    logic signed [15:0] d16;
    longint             acc;
    assign d16 = lms_delta[15:0];
    always @(posedge clk) begin
        if (lms_load) begin
            for (int i = 0; i < 4; i++) begin
                eh[i] <= lms_load_history[i];
                ew[i] <= lms_load_weights[i];
            end
        end else if (lms_update) begin
            for (int i = 0; i < 4; i++) ew[i] <= ew[i] + ((eh[i] < 0) ? -d16 : d16);
            eh[0] <= eh[1]; eh[1] <= eh[2]; eh[2] <= eh[3]; eh[3] <= lms_sample[15:0];
        end
    end
    always_comb begin
        acc = 0;
        for (int i = 0; i < 4; i++) acc += longint'(eh[i]) * longint'(ew[i]);
        for (int i = 0; i < 4; i++) begin
            lms_save_history[i] = eh[i];
            lms_save_weights[i] = ew[i];
        end
    end
    assign lms_prediction = 32'(acc >>> 13);

    // Golden decoder state and expected-sample queue.
    typedef struct { int s; int ch; bit last; } exp_t;
    exp_t    sbq[$];
    exp_t    me;
    shortint gh [8][4];
    shortint gw [8][4];

    function automatic int bdq(input int sf, input int q);
        int s, m;
        s = SFT[sf];
        case (q >> 1)
            0: m = (3 * s + 2) / 4;
            1: m = (5 * s + 1) / 2;
            2: m = (9 * s + 1) / 2;
            default: m = 7 * s;
        endcase
        return ((q & 1) != 0) ? -m : m;
    endfunction

    task automatic gold_slice(input int ch, input logic [63:0] d);
        longint p;
        int pred, r, v, dl;
        for (int k = 0; k < 20; k++) begin
            p = 0;
            for (int i = 0; i < 4; i++) p += longint'(gh[ch][i]) * longint'(gw[ch][i]);
            pred = int'(p >>> 13);
            r = bdq(int'(d[63:60]), int'(d[59 - 3 * k -: 3]));
            v = pred + r;
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            dl = r >>> 4;
            for (int i = 0; i < 4; i++) gw[ch][i] = shortint'(gw[ch][i] + ((gh[ch][i] < 0) ? -dl : dl));
            for (int i = 0; i < 3; i++) gh[ch][i] = gh[ch][i + 1];
            gh[ch][3] = shortint'(v);
            sbq.push_back('{v, ch, (k == 19)});
        end
    endtask

    // Output monitor: every handshake is matched against the queue front.
    always @(negedge clk) begin
        if (!rst && sif.out_valid && sif.out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_sample: got %0d with nothing expected", sif.out_sample);
            end else begin
                me = sbq.pop_front();
                chk("out_sample", sif.out_sample, me.s);
                chk("out_ch", sif.out_ch, me.ch);
                chk("out_last", sif.out_last, me.last);
            end
        end
        if (lms_load) chk("load_update_excl", lms_update, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st_write(input int ch, input int h, input int w, input bit upd);
        st_wr = 1'b1;
        st_ch = 3'(ch);
        for (int i = 0; i < 4; i++) begin
            st_history[i] = 16'(h);
            st_weights[i] = 16'(w);
        end
        tick();
        st_wr = 1'b0;
        if (upd && ch < NUM_CH) begin
            for (int i = 0; i < 4; i++) begin
                gh[ch][i] = shortint'(h);
                gw[ch][i] = shortint'(w);
            end
        end
    endtask

    task automatic send_slice(input int ch, input logic [63:0] d, input bit bad, input bit chkf, input int first);
        logic [3:0][15:0] hx, wx;
        for (int i = 0; i < 4; i++) begin
            hx[i] = 16'(gh[ch][i]);
            wx[i] = 16'(gw[ch][i]);
        end
        sif.slice_valid = 1'b1;
        sif.slice_data  = d;
        sif.slice_ch    = 3'(ch);
        @(negedge clk);
        chk("slice_ready_idle", sif.slice_ready, 1);
        tick();
        sif.slice_valid = 1'b0;
        if (!bad) gold_slice(ch, d);
        @(negedge clk);
        if (bad) begin
            chk("err_pulse", err, 1);
            chk("bad_no_load", lms_load, 0);
        end else begin
            chk("lms_load", lms_load, 1);
            chk("load_no_valid", sif.out_valid, 0);
            chk("load_history", lms_load_history, hx);
            chk("load_weights", lms_load_weights, wx);
            chk("ready_busy", sif.slice_ready, 0);
        end
        @(negedge clk);
        if (bad) begin
            chk("err_one_cycle", err, 0);
            chk("bad_no_valid", sif.out_valid, 0);
            chk("bad_ready", sif.slice_ready, 1);
        end else begin
            chk("first_valid", sif.out_valid, 1);
            if (chkf) chk("first_sample", sif.out_sample, first);
        end
        tick();
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sbq.size() != 0 || sif.slice_ready !== 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk("slice_drained", sbq.size(), 0);
        chk("back_to_idle", sif.slice_ready, 1);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_out_valid"}, sif.out_valid, 0);
        chk({nm, "_lms_load"}, lms_load, 0);
        chk({nm, "_lms_update"}, lms_update, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_out_sample"}, sif.out_sample, 0);
        chk({nm, "_out_ch"}, sif.out_ch, 0);
        chk({nm, "_out_last"}, sif.out_last, 0);
        chk({nm, "_lms_sample"}, lms_sample, 0);
        chk({nm, "_lms_delta"}, lms_delta, 0);
        chk({nm, "_slice_ready"}, sif.slice_ready, 0);
    endtask

    function automatic logic [63:0] mk(input int sf, input int q);
        logic [2:0] q3;
        q3 = 3'(q);
        return {4'(sf), {20{q3}}};
    endfunction

    function automatic logic [63:0] rnd(input int sf);
        return {4'(sf), 60'({$urandom(), $urandom()})};
    endfunction

    typedef struct { bit st; int ch; int h; int w; logic [63:0] d; bit bad; bit chkf; int first; } vec_t;
    vec_t vt [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic signed [15:0] held;
        for (int c = 0; c < 8; c++) for (int i = 0; i < 4; i++) begin gh[c][i] = 0; gw[c][i] = 0; end
        sif.slice_valid = 1'b0;
        sif.slice_data  = 64'd0;
        sif.slice_ch    = 3'd0;
        sif.out_ready   = 1'b1;

        vt[0] = '{1'b0, 0, 0, 0, mk(0, 2), 1'b0, 1'b1, 3};
        vt[1] = '{1'b0, 0, 0, 0, mk(0, 2), 1'b0, 1'b1, 3};
        vt[2] = '{1'b1, 0, 32767, 8192, mk(0, 0), 1'b0, 1'b1, 32767};
        vt[3] = '{1'b1, 0, -256, 2048, mk(2, 1), 1'b0, 1'b1, -272};
        vt[4] = '{1'b1, 1, 100, 4096, mk(1, 2), 1'b0, 1'b1, 218};
        vt[5] = '{1'b0, 0, 0, 0, rnd(5), 1'b0, 1'b0, 0};
        vt[6] = '{1'b0, 5, 0, 0, mk(3, 3), 1'b1, 1'b0, 0};
        vt[7] = '{1'b0, 1, 0, 0, rnd(15), 1'b0, 1'b0, 0};
        vt[8] = '{1'b1, 0, -32768, 32767, mk(0, 7), 1'b0, 1'b1, -32768};
        vt[9] = '{1'b0, 0, 0, 0, rnd(9), 1'b0, 1'b0, 0};

        @(negedge clk);
        chk_quiet("reset");
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", sif.slice_ready, 1);
        tick();

        for (int v = 0; v < 10; v++) begin
            if (vt[v].st) st_write(vt[v].ch, vt[v].h, vt[v].w, 1'b1);
            send_slice(vt[v].ch, vt[v].d, vt[v].bad, vt[v].chkf, vt[v].first);
            if (!vt[v].bad) wait_done();
        end

        // back-pressure for five cycles while sample 7 is presented
        send_slice(1, rnd(7), 1'b0, 1'b0, 0);
        repeat (6) tick();
        sif.out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", sif.out_valid, 1);
            chk("stall_sample", sif.out_sample, sbq[0].s);
            chk("stall_no_update", lms_update, 0);
        end
        @(posedge clk);
        #1;
        sif.out_ready = 1'b1;
        wait_done();

        // header write into the channel being decoded must not disturb it
        send_slice(0, rnd(4), 1'b0, 1'b0, 0);
        repeat (4) tick();
        st_write(0, 1234, -500, 1'b0);
        wait_done();

        // header write landing in the save cycle wins; out-of-range channel ignored
        send_slice(1, mk(4, 5), 1'b0, 1'b0, 0);
        n = 0;
        while (!(sif.out_valid && sif.out_last && sif.out_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("found_last", (n < 100), 1);
        @(posedge clk);
        #1;
        st_write(1, 777, 3000, 1'b1);
        wait_done();
        st_write(3, 999, 999, 1'b1);
        send_slice(1, mk(0, 1), 1'b0, 1'b1, 1137);
        wait_done();
        send_slice(0, rnd(11), 1'b0, 1'b0, 0);
        wait_done();

        // reset in the middle of a slice
        st_write(0, 2000, 1000, 1'b1);
        send_slice(0, rnd(6), 1'b0, 1'b0, 0);
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk_quiet("midrst");
        sbq.delete();
        for (int c = 0; c < 8; c++) for (int i = 0; i < 4; i++) begin gh[c][i] = 0; gw[c][i] = 0; end
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", sif.slice_ready, 1);
        tick();
        send_slice(0, mk(0, 2), 1'b0, 1'b1, 3);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qoa_slice_sequencer.md
QOA_SLICE_SEQUENCER -- requirements
Module: qoa_slice_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of audio channels sharing one lms instance (1..8).
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: slice_valid in 1, slice_ready out 1, slice_data in 64 (bits 63:60 scalefactor, then 20 x 3-bit residuals with residual 0 at 59:57), slice_ch in 3.
REQ-004 SHALL have ports: st_wr in 1, st_ch in 3, st_history in 4x16 signed, st_weights in 4x16 signed (per-channel LMS state from frame header).
REQ-005 SHALL have ports: out_valid out 1, out_ready in 1, out_sample out 16 signed, out_ch out 3, out_last out 1 (20th sample of slice).
REQ-006 SHALL have LMS-side ports: lms_load out 1, lms_load_history out 4x16, lms_load_weights out 4x16, lms_prediction in 32 signed (already >>13), lms_update out 1, lms_sample out 32 signed, lms_delta out 28 signed, lms_save_history in 4x16, lms_save_weights in 4x16.
REQ-007 SHALL have port err out 1: one-cycle pulse on a rejected slice.

Function
REQ-008 SHALL hold a state table of NUM_CH entries {history[4], weights[4]}.
REQ-009 SHALL implement FSM states IDLE, LOAD, RUN, SAVE.
REQ-010 IDLE: slice_ready=1; on slice_valid&slice_ready latch slice_data/slice_ch, go LOAD; if slice_ch>=NUM_CH, pulse err next cycle, stay IDLE.
REQ-011 LOAD: assert lms_load for exactly one cycle with table[ch], go RUN; first out_valid in the following cycle (2 cycles after slice acceptance).
REQ-012 RUN: residual index k counts 0..19; r = dequant_tab[sf][q_k]; out_sample = clamp(lms_prediction + r, -32768, 32767), computed combinationally from lms_prediction.
REQ-013 RUN: out_valid=1; lms_update = out_valid & out_ready; lms_sample = sign-extended out_sample; lms_delta = r >>> 4 (arithmetic).
REQ-014 out_valid/out_sample/out_ch/out_last SHALL stay stable while out_ready=0; k SHALL NOT advance and lms_update SHALL stay 0.
REQ-015 Throughput SHALL be one sample per cycle with out_ready held high; out_last=1 only at k=19.
REQ-016 On handshake at k=19 go SAVE; in SAVE write lms_save_history/lms_save_weights into table[ch], go IDLE (slice_ready=0 during LOAD, RUN, SAVE).
REQ-017 st_wr SHALL be accepted in every state and write table[st_ch] in one cycle; st_ch>=NUM_CH is ignored.
REQ-018 st_wr in the SAVE cycle to the same channel SHALL win over the save write.
REQ-019 st_wr to the active channel during LOAD/RUN SHALL NOT disturb the slice in progress.
REQ-020 lms_load and lms_update SHALL never assert in the same cycle.

Reset
REQ-021 On rst: FSM=IDLE, k=0; all table entries history=0, weights=0.
REQ-022 On rst: slice_ready=0 while rst high, 1 in the first cycle after release.
REQ-023 On rst: out_valid, lms_load, lms_update, err =0; out_sample, out_ch, out_last, lms_sample, lms_delta =0.
REQ-024 rst mid-slice SHALL abandon the slice without a SAVE write.

Structure
REQ-025 Package qoa_pkg SHALL hold: SLICE_LEN=20, the 16x8 dequant_tab (scalefactor round((s+1)^2.75) times {0.75,-0.75,2.5,-2.5,4.5,-4.5,7,-7}, rounded away from zero), the lms_state_t struct, and the state enum.
REQ-026 One sub-module qoa_dequant SHALL be combinational (sf, q -> r, 17-bit signed).

Verification
REQ-027 Zero state ch0, slice sf=0, all q=2 -> 20 samples of 3, out_last on 20th, table[0] history={3,3,3,3}, weights={0,0,0,0}.
REQ-028 st_wr ch0 history all 32767, weights all 8192; slice sf=0 q=0 -> prediction 131068, out_sample clamps to 32767.
REQ-029 out_ready low 5 cycles at k=7 -> out_sample held, lms_update 0 throughout, 20 samples total, none duplicated.
REQ-030 Interleaved slices ch0, ch1, ch0 with distinct st_wr states -> ch0 second slice matches a golden model continuing ch0 state only.
REQ-031 slice_ch=5 with NUM_CH=2 -> err pulse, no out_valid, table unchanged.
REQ-032 rst asserted at k=10 -> outputs 0 immediately, table zeroed, next slice starts from zero state.
